// File: rtl/router_1xn_fifo.sv
// 1-to-N router: each accepted word lands in the show-ahead FIFO of its destination port.
// Optional build macro ROUTER_PARITY_EN adds an even-parity input check and a parity error counter.
module router_1xn_fifo #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 3,
  parameter int DEPTH   = 4,
  localparam int DEST_W = ($clog2(NUM_OUT) < 1) ? 1 : $clog2(NUM_OUT),
  localparam int FILL_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [DEST_W-1:0]           in_dest,
`ifdef ROUTER_PARITY_EN
  input  logic                        in_parity,
  output logic [7:0]                  perr_cnt,
`endif
  output logic [NUM_OUT-1:0]          out_valid,
  input  logic [NUM_OUT-1:0]          out_ready,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic [NUM_OUT*FILL_W-1:0]   fill,
  output logic [7:0]                  drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DEST_W:0]   NUM_OUT_C = (DEST_W+1)'(NUM_OUT);
  localparam logic [FILL_W-1:0] DEPTH_C   = FILL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q    [NUM_OUT][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_OUT];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_OUT];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_OUT];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_OUT];
  logic [FILL_W-1:0] cnt_q    [NUM_OUT];
  logic [FILL_W-1:0] cnt_d    [NUM_OUT];
  logic [7:0]        drop_q, drop_d;

  logic               dest_ok;
  logic               dest_full;
  logic               par_ok;
  logic               xfer;
  logic               drop;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;

`ifdef ROUTER_PARITY_EN
  logic [7:0] perr_q, perr_d;
  logic       perr;

  assign par_ok = ~(^{in_data, in_parity});
  assign perr   = xfer & ~par_ok;
  assign perr_d = (perr && perr_q != 8'hFF) ? perr_q + 8'd1 : perr_q;
  assign perr_cnt = perr_q;

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 8'd0;
    else     perr_q <= perr_d;
  end
`else
  assign par_ok = 1'b1;
`endif

  assign dest_ok = ({1'b0, in_dest} < NUM_OUT_C);

  // Fullness uses the registered count only, so a same-cycle pop never makes room.
  always_comb begin
    dest_full = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_dest == DEST_W'(k)) dest_full = (cnt_q[k] == DEPTH_C);
    end
  end

  assign in_ready = ~par_ok | ~dest_ok | ~dest_full;
  assign xfer     = in_valid & in_ready;
  assign drop     = xfer & par_ok & ~dest_ok;
  assign drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      push[k] = xfer & par_ok & (in_dest == DEST_W'(k));
      pop[k]  = (cnt_q[k] != '0) & out_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + PTR_W'(1) : wr_ptr_q[k];
      rd_ptr_d[k] = pop[k]  ? rd_ptr_q[k] + PTR_W'(1) : rd_ptr_q[k];
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + FILL_W'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - FILL_W'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      drop_q <= 8'd0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
      drop_q <= drop_d;
    end
  end

  // Storage is left unreset; out_data is only meaningful while out_valid is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (!rst && push[k]) mem_q[k][wr_ptr_q[k]] <= in_data;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OUT; g++) begin : g_port
      assign out_valid[g]                  = (cnt_q[g] != '0);
      assign out_data[g*DATA_W +: DATA_W]  = mem_q[g][rd_ptr_q[g]];
      assign fill[g*FILL_W +: FILL_W]      = cnt_q[g];
    end
  endgenerate

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_router_1xn_fifo.sv
// Directed bench for router_1xn_fifo (3 ports, depth 4) with a per-port scoreboard and output monitor.
module tb_router_1xn_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [23:0] out_data;
  logic [8:0]  fill;
  logic [7:0]  drop_cnt;
`ifdef ROUTER_PARITY_EN
  logic        in_parity;
  logic [7:0]  perr_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] mon_e;
  int         mon_n;

  router_1xn_fifo #(.DATA_W(8), .NUM_OUT(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest),
`ifdef ROUTER_PARITY_EN
    .in_parity(in_parity), .perr_cnt(perr_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill(fill), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int fill_of(int k);
    return int'(fill[k*3 +: 3]);
  endfunction

  function automatic int data_of(int k);
    return int'(out_data[k*8 +: 8]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [7:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          mon_n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
          if (mon_n == 0) begin
            total++;
            bad++;
            $display("FAIL port%0d_unexpected: got 0x%0h expected no word", k, data_of(k));
          end else begin
            mon_e = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
            chk($sformatf("port%0d_data", k), data_of(k), int'(mon_e));
          end
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the edge that accepts the word.
  task automatic send(input logic [7:0] d, input logic [1:0] dest, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dest;
`ifdef ROUTER_PARITY_EN
    in_parity = ^d;
`endif
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles (dest %0d)", dest);
    end else if (dest < 2'd3) begin
      sb_push(int'(dest), d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int anywait;
    int anyfill;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 3'b000;
`ifdef ROUTER_PARITY_EN
    in_parity = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_fill", int'(fill), 0);
    chk("reset_drop_cnt", int'(drop_cnt), 0);
`ifdef ROUTER_PARITY_EN
    chk("reset_perr_cnt", int'(perr_cnt), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // one word to each port, consumers always ready
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      send(8'hAA, 2'(d), w);
      chk($sformatf("t1_out_valid_dest%0d", d), int'(out_valid), 1 << d);
      chk($sformatf("t1_head_dest%0d", d), data_of(d), 'hAA);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t1_fill_zero", int'(fill), 0);

    // backpressure on port 1
    out_ready = 3'b101;
    for (int i = 1; i <= 4; i++) send(8'(i), 2'd1, w);
    in_valid = 1'b1; in_data = 8'h05; in_dest = 2'd1;
`ifdef ROUTER_PARITY_EN
    in_parity = ^8'h05;
`endif
    @(negedge clk);
    chk("t2_in_ready_full", int'(in_ready), 0);
    chk("t2_fill1_full", fill_of(1), 4);
    @(posedge clk);
    #1;
    out_ready = 3'b111;
    @(negedge clk);
    chk("t2_no_push_while_popping_full", int'(in_ready), 0);
    send(8'h05, 2'd1, w);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_fill1_drained", fill_of(1), 0);
    chk("t2_q1_empty", q1.size(), 0);

    // bad destination flood
    anywait = 0;
    anyfill = 0;
    for (int i = 1; i <= 300; i++) begin
      send(8'(i), 2'd3, w);
      if (w != 0) anywait++;
      if (fill != 9'd0) anyfill++;
      if (i == 100) chk("t3_drop_cnt_100", int'(drop_cnt), 100);
    end
    chk("t3_never_stalled", anywait, 0);
    chk("t3_fill_stays_zero", anyfill, 0);
    chk("t3_drop_cnt_saturated", int'(drop_cnt), 255);

    // full port 0 must not block port 2
    out_ready = 3'b110;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 2'd0, w);
    chk("t4_fill0_full", fill_of(0), 4);
    send(8'hC2, 2'd2, w);
    chk("t4_port2_no_wait", w, 0);
    chk("t4_fill0_unchanged", fill_of(0), 4);
    chk("t4_head0_unchanged", data_of(0), 'hB0);

    // simultaneous push and pop on port 0
    out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("t5_fill0_one", fill_of(0), 1);
    out_ready[0] = 1'b1;
    send(8'hD0, 2'd0, w);
    out_ready[0] = 1'b0;
    chk("t5_fill0_push_pop_at_1", fill_of(0), 1);
    chk("t5_head0_after_push_pop", data_of(0), 'hD0);
    for (int i = 1; i <= 3; i++) send(8'hE0 + 8'(i), 2'd0, w);
    chk("t5_fill0_full_again", fill_of(0), 4);
    out_ready[0] = 1'b1;
    in_valid = 1'b1; in_data = 8'hE4; in_dest = 2'd0;
`ifdef ROUTER_PARITY_EN
    in_parity = ^8'hE4;
`endif
    @(negedge clk);
    chk("t5_push_refused_at_4", int'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready[0] = 1'b0;
    chk("t5_fill0_three", fill_of(0), 3);
    out_ready = 3'b111;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_all_drained", int'(fill), 0);
    chk("t5_q0_empty", q0.size(), 0);

    // reset mid-drain, with a word presented during the reset cycle
    out_ready = 3'b011;
    send(8'hF1, 2'd2, w);
    send(8'hF2, 2'd2, w);
    send(8'hF3, 2'd2, w);
    out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd2;
`ifdef ROUTER_PARITY_EN
    in_parity = ^8'h77;
`endif
    q2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t6_out_valid_after_rst", int'(out_valid), 0);
    chk("t6_fill_after_rst", int'(fill), 0);
    chk("t6_drop_cnt_after_rst", int'(drop_cnt), 0);
    send(8'h5A, 2'd2, w);
    chk("t6_out_valid_after_push", int'(out_valid), 4);
    chk("t6_head2_after_push", data_of(2), 'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_fill_final", int'(fill), 0);

`ifdef ROUTER_PARITY_EN
    in_valid = 1'b1; in_data = 8'h01; in_dest = 2'd0; in_parity = 1'b0;
    @(negedge clk);
    chk("par_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("par_perr_cnt", int'(perr_cnt), 1);
    chk("par_fill", int'(fill), 0);
    chk("par_drop_cnt", int'(drop_cnt), 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("end_scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
